// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-predictor table scheduler.
package bp_pkg;

   // Scheduler states: full-table initialise sweep, or normal operation.
   typedef enum logic {
      SWEEP = 1'b0,
      RUN   = 1'b1
   } bp_sched_state_t;

   // Number of table entries for a given index width.
   function automatic int unsigned table_entries(input int unsigned idx_w);
      return 32'd1 << idx_w;
   endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO holding pending table updates (index/data records).
module bp_update_fifo #(
   parameter int unsigned W     = 38,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full && !clear;
   assign pop_ok  = pop && !empty && !clear;
   assign rdata   = mem[rd_ptr];

   // Storage array; written only on an accepted push.
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bp_table_scheduler.sv
// Arbitrates a single-port predictor table between fetch lookups, buffered
// execute updates and a full-table initialise sweep.
module bp_table_scheduler
   import bp_pkg::*;
#(
   parameter int unsigned         IDX_W    = 6,
   parameter int unsigned         ENTRY_W  = 32,
   parameter int unsigned         QDEPTH   = 4,
   parameter int unsigned         MAX_WAIT = 8,
   parameter logic [ENTRY_W-1:0]  INIT_VAL = '0
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               lookup_valid,
   input  logic [IDX_W-1:0]   lookup_index,
   output logic               lookup_ready,
   output logic               lookup_rvalid,
   output logic [ENTRY_W-1:0] lookup_rdata,
   input  logic               upd_valid,
   input  logic [IDX_W-1:0]   upd_index,
   input  logic [ENTRY_W-1:0] upd_data,
   output logic               upd_ready,
   input  logic               flush_req,
   output logic               busy,
   output logic               tbl_en,
   output logic               tbl_we,
   output logic [IDX_W-1:0]   tbl_addr,
   output logic [ENTRY_W-1:0] tbl_wdata,
   input  logic [ENTRY_W-1:0] tbl_rdata
);

   localparam int unsigned TABLE_ENTRIES = table_entries(IDX_W);
   localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam int unsigned CNT_W  = $clog2(QDEPTH) + 1;

   // Update record is sized by this instance's parameters, so it is local.
   typedef struct packed {
      logic [IDX_W-1:0]   index;
      logic [ENTRY_W-1:0] data;
   } bp_update_t;

   bp_sched_state_t   state;
   logic [IDX_W-1:0]  sweep_cnt;
   logic [WAIT_W-1:0] wait_cnt;

   bp_update_t        fifo_in;
   bp_update_t        fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              push;
   logic              pop;
   logic              read_grant;
   logic              force_upd;

   assign fifo_in.index = upd_index;
   assign fifo_in.data  = upd_data;
   assign push          = upd_valid && upd_ready && !flush_req;
   assign busy          = (state == SWEEP);
   assign lookup_rdata  = tbl_rdata;

   bp_update_fifo #(
      .W     ($bits(bp_update_t)),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .clear (flush_req),
      .push  (push),
      .pop   (pop),
      .wdata (fifo_in),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Grant selection and RAM port drive; lookups win unless the update head has aged out.
   always_comb begin
      force_upd    = !fifo_empty && (fifo_full || (wait_cnt >= WAIT_W'(MAX_WAIT)));
      lookup_ready = 1'b0;
      upd_ready    = 1'b0;
      read_grant   = 1'b0;
      pop          = 1'b0;
      tbl_en       = 1'b0;
      tbl_we       = 1'b0;
      tbl_addr     = '0;
      tbl_wdata    = '0;
      case (state)
         SWEEP: begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_addr  = sweep_cnt;
            tbl_wdata = INIT_VAL;
         end
         RUN: begin
            lookup_ready = !force_upd;
            upd_ready    = (fifo_count < CNT_W'(QDEPTH));
            read_grant   = lookup_valid && lookup_ready;
            if (read_grant) begin
               tbl_en   = 1'b1;
               tbl_addr = lookup_index;
            end else if (!fifo_empty && !flush_req) begin
               // Pending updates are discarded by a flush, so none is written in that cycle.
               pop       = 1'b1;
               tbl_en    = 1'b1;
               tbl_we    = 1'b1;
               tbl_addr  = fifo_head.index;
               tbl_wdata = fifo_head.data;
            end
         end
         default: begin
         end
      endcase
   end

   // Scheduler FSM, sweep counter, update aging counter and read-valid register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state         <= SWEEP;
         sweep_cnt     <= '0;
         wait_cnt      <= '0;
         lookup_rvalid <= 1'b0;
      end else begin
         lookup_rvalid <= read_grant;
         if (flush_req) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
            wait_cnt  <= '0;
         end else begin
            case (state)
               SWEEP: begin
                  sweep_cnt <= sweep_cnt + 1'b1;
                  if (sweep_cnt == IDX_W'(TABLE_ENTRIES - 1)) begin
                     state <= RUN;
                  end
               end
               RUN: begin
                  if (pop || fifo_empty) begin
                     wait_cnt <= '0;
                  end else if (wait_cnt < WAIT_W'(MAX_WAIT)) begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
               default: state <= SWEEP;
            endcase
         end
      end
   end

endmodule
